// File: rtl/vrf_pkg.sv
// Shared types and defaults for the vector register file.
package vrf_pkg;

  localparam int VRF_NREGS = 10;
  localparam int VRF_LANES = 6;
  localparam int VRF_LW    = 8;

  typedef logic [VRF_LANES-1:0][VRF_LW-1:0] vec_t;

  typedef enum logic {
    VRF_CLEAR,
    VRF_READY
  } vrf_state_e;

  function automatic logic idx_ok(
    input int unsigned idx,
    input int unsigned n
  );
    return idx < n;
  endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Pending-write busy bits for decode hazard detection.
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int NREGS = VRF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] q1,
  input  logic [AW-1:0] q2,
  output logic          b1,
  output logic          b2
);

  logic [NREGS-1:0] busy;

  // Set is applied last so a new producer outranks a completing write.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign b1 = idx_ok(32'(q1), NREGS) && busy[q1];
  assign b2 = idx_ok(32'(q2), NREGS) && busy[q2];

endmodule

// File: rtl/vector_regfile_mp.sv
// Vector register file: 2 bypassed read ports, lane-masked
// write port, post-reset clear sweep and busy scoreboard.
module vector_regfile_mp
  import vrf_pkg::*;
#(
  parameter int  NREGS = VRF_NREGS,
  parameter int  LANES = VRF_LANES,
  parameter int  LW    = VRF_LW,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [LANES-1:0]    wmask,
  input  logic [LANES*LW-1:0] wd,
  input  logic [AW-1:0]       ra1,
  input  logic [AW-1:0]       ra2,
  output logic [LANES*LW-1:0] rd1,
  output logic [LANES*LW-1:0] rd2,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_idx,
  output logic                busy1,
  output logic                busy2
);

  typedef logic [LANES-1:0][LW-1:0] lvec_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  vrf_state_e  state;
  logic [AW-1:0] cnt;
  lvec_t       rf [NREGS];
  lvec_t       wd_v;
  logic        w_ok;
  logic        r_ok;
  logic        sb_b1;
  logic        sb_b2;

  assign wd_v = wd;
  assign w_ok = ready && we && idx_ok(32'(wa), NREGS);
  assign r_ok = ready && rsv_en && idx_ok(32'(rsv_idx), NREGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= VRF_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        VRF_CLEAR: begin
          if (cnt == LAST) begin
            state <= VRF_READY;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        VRF_READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= VRF_CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == VRF_CLEAR) begin
      rf[cnt] <= '0;
    end else if (w_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) rf[wa][i] <= wd_v[i];
      end
    end
  end

  function automatic lvec_t rd_port(input logic [AW-1:0] ra);
    lvec_t v;
    v = '0;
    if (ready && idx_ok(32'(ra), NREGS)) begin
      v = rf[ra];
      if (w_ok && wa == ra) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) v[i] = wd_v[i];
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    rd1 = rd_port(ra1);
    rd2 = rd_port(ra2);
  end

  vrf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (r_ok),
    .set_idx (rsv_idx),
    .clr_en  (w_ok),
    .clr_idx (wa),
    .q1      (ra1),
    .q2      (ra2),
    .b1      (sb_b1),
    .b2      (sb_b2)
  );

  assign busy1 = ready && sb_b1 && !(we && wa == ra1);
  assign busy2 = ready && sb_b2 && !(we && wa == ra2);

endmodule
